// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard unit for a five-stage in-order pipeline (F D E M W). It produces:
//   - E-stage operand forwarding selects (purely combinational),
//   - load-use stall, branch flush and memory-wait stall/bubble controls,
//   - a memory-wait watchdog FSM (RUN / MEM_WAIT / FAULT) with a sticky
//     fault flag,
//   - two saturating performance counters (stall cycles, E-flush cycles).
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   Rs1D, Rs2D                source registers of the instruction in D
//   Rs1E, Rs2E, RdE           sources / destination of the instruction in E
//   RdM, RegWriteM            destination / write-enable of the instruction in M
//   RdW, RegWriteW            destination / write-enable of the instruction in W
//   ResultSrcE                2'b01 marks a load in E
//   PCSrcE                    taken branch or jump resolving in E
//   MemReqM, MemReadyM        data-memory access in M / completes this cycle
//   ForwardAE, ForwardBE      00 register file, 01 W result, 10 M ALU result
//   StallF..StallM            hold the corresponding stage register
//   FlushD, FlushE, FlushW    insert a bubble into the corresponding stage
//   MemErr                    sticky memory-timeout fault (state is FAULT)
//   StallCnt, FlushCnt        saturating cycle counters (StallF / FlushE)
//   dbg_state_o               current FSM state: 0 RUN, 1 MEM_WAIT, 2 FAULT
//
// There is no valid/ready handshake on this block: every input is a level
// describing the current pipeline contents and is evaluated each cycle.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt,
  output logic [1:0]           dbg_state_o
);

  // Wait counter is at least 8 bits and always wide enough to hold WAIT_LIMIT.
  localparam int WL_BITS = $clog2(WAIT_LIMIT + 1);
  localparam int WCW     = (WL_BITS > 8) ? WL_BITS : 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic lw_stall;
  logic mem_busy;

  // -------------------------------------------------------------------------
  // Forwarding: M has priority over W because it holds the younger result.
  // Register x0 is never forwarded.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_busy = MemReqM && !MemReadyM;

  // -------------------------------------------------------------------------
  // Memory-wait watchdog FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(WAIT_LIMIT)) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      FAULT: begin
        // Only reset leaves FAULT.
        state_d = FAULT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stall / flush controls, highest priority first. A memory stall freezes
  // F..M, so a branch or load-use hazard sitting in E/D is held and acted on
  // once memory releases. FlushW keeps the stalled M instruction from
  // retiring twice into W.
  // -------------------------------------------------------------------------
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      // All controls held inactive during reset.
    end else if ((state_q == FAULT) || mem_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (FlushE && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr      = (state_q == FAULT);
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed cases followed by randomized cycles. A behavioural model tracks
// the fault flag, the number of consecutive memory-wait cycles and the two
// counters as plain integers; expected outputs are derived from the
// hazard-priority rules each cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int WL      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic          MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;
  logic [1:0]    dbg_state_o;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
    .dbg_state_o(dbg_state_o)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_wait  = 0;   // consecutive memory-wait cycles, 0 when not waiting
  bit m_fault = 1'b0;
  int m_scnt  = 0;
  int m_fcnt  = 0;

  // expected outputs for the current cycle
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compute_exp();
    bit busy, lw;
    busy = MemReqM && !MemReadyM;
    lw   = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    e_fa = ref_fwd(Rs1E);
    e_fb = ref_fwd(Rs2E);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = 7'b0;
    if (rst) begin
    end else if (m_fault || busy) begin
      {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
    end else if (PCSrcE) begin
      {e_fd, e_fe} = 2'b11;
    end else if (lw) begin
      {e_sf, e_sd, e_fe} = 3'b111;
    end
  endtask

  task automatic check_all();
    int exp_state;
    compute_exp();
    exp_state = m_fault ? 2 : ((m_wait != 0) ? 1 : 0);
    check("ForwardAE", 32'(ForwardAE), 32'(e_fa));
    check("ForwardBE", 32'(ForwardBE), 32'(e_fb));
    check("StallF",    32'(StallF),    32'(e_sf));
    check("StallD",    32'(StallD),    32'(e_sd));
    check("StallE",    32'(StallE),    32'(e_se));
    check("StallM",    32'(StallM),    32'(e_sm));
    check("FlushD",    32'(FlushD),    32'(e_fd));
    check("FlushE",    32'(FlushE),    32'(e_fe));
    check("FlushW",    32'(FlushW),    32'(e_fw));
    check("MemErr",    32'(MemErr),    32'(m_fault));
    check("StallCnt",  32'(StallCnt),  32'(m_scnt));
    check("FlushCnt",  32'(FlushCnt),  32'(m_fcnt));
    check("state",     32'(dbg_state_o), 32'(exp_state));
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_edge();
    bit busy;
    busy = MemReqM && !MemReadyM;
    if (e_sf && m_scnt < CNT_MAX) m_scnt++;
    if (e_fe && m_fcnt < CNT_MAX) m_fcnt++;
    if (!m_fault) begin
      if (m_wait == 0) begin
        if (busy) m_wait = 1;
      end else if (MemReadyM) begin
        m_wait = 0;
      end else if (m_wait == WL) begin
        m_fault = 1'b1;
      end else begin
        m_wait++;
      end
    end
  endtask

  // Inputs are applied just after a falling edge; check, clock, settle.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_wait = 0; m_fault = 1'b0; m_scnt = 0; m_fcnt = 0;
  endtask

  // Asynchronous reset asserted mid-cycle, held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic random_inputs();
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
    Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
    RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
    RdW  = 5'($urandom_range(0, 7));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE     = ($urandom_range(0, 3) == 0);
    MemReqM    = ($urandom_range(0, 2) == 0);
    MemReadyM  = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    // reset state, with forwarding still live
    RegWriteM = 1; RdM = 3; Rs2E = 3; MemReqM = 1; PCSrcE = 1;
    #1;
    check_all();
    check("rst_fwdB", 32'(ForwardBE), 32'd2);
    check("rst_stallF", 32'(StallF), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // forwarding priority
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    #1; check("fwd_M", 32'(ForwardAE), 32'd2); step();
    RdM = 0;
    #1; check("fwd_W", 32'(ForwardAE), 32'd1); step();
    Rs1E = 0; RdW = 0;
    #1; check("fwd_RF", 32'(ForwardAE), 32'd0); step();

    // load-use stall, then branch beats load-use
    do_reset();
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    check("lw_stallF", 32'(StallF), 32'd1);
    check("lw_flushE", 32'(FlushE), 32'd1);
    step();
    clear_inputs();
    #1; check("lw_cnt", 32'(StallCnt), 32'd1); step();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1;
    check("br_flushD", 32'(FlushD), 32'd1);
    check("br_stallF", 32'(StallF), 32'd0);
    step();

    // memory wait released after three busy cycles
    do_reset();
    clear_inputs();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stallM", 32'(StallM), 32'd1);
      check("mw_flushW", 32'(FlushW), 32'd1);
      step();
    end
    MemReadyM = 1;
    #1;
    check("mw_rel_stall", 32'(StallF), 32'd0);
    check("mw_rel_state", 32'(dbg_state_o), 32'd1);
    step();
    clear_inputs();
    #1;
    check("mw_state_run", 32'(dbg_state_o), 32'd0);
    check("mw_cnt", 32'(StallCnt), 32'd3);
    step();

    // branch held during memory wait, acted on at release
    do_reset();
    clear_inputs();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      #1; check("hold_flushE", 32'(FlushE), 32'd0); step();
    end
    MemReadyM = 1;
    #1; check("rel_flushD", 32'(FlushD), 32'd1); step();
    clear_inputs();
    #1; check("rel_fcnt", 32'(FlushCnt), 32'd1); step();

    // timeout into FAULT, sticky until reset
    do_reset();
    clear_inputs();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) step();
    #1; check("pre_fault", 32'(MemErr), 32'd0);
    step();
    #1; check("fault", 32'(MemErr), 32'd1);
    clear_inputs();
    MemReadyM = 1;
    step();
    step();
    #1; check("fault_sticky", 32'(MemErr), 32'd1);
    check("fault_stallE", 32'(StallE), 32'd1);
    do_reset();
    check("fault_cleared", 32'(MemErr), 32'd0);

    // counter saturation
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
    for (int i = 0; i < 20; i++) step();
    clear_inputs();
    #1; check("sat_cnt", 32'(StallCnt), 32'd15);
    step();

    // randomized cycles with occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      random_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter WAIT_LIMIT, default 255, the maximum consecutive memory-wait cycles before a fault.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, the width of each performance counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The module SHALL have inputs Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, each 5 bits: register indices per stage.
REQ-006 The module SHALL have inputs RegWriteM and RegWriteW, each 1 bit: a write is pending in M or W.
REQ-007 The module SHALL have input ResultSrcE, 2 bits: a value of 2'b01 marks a load in E.
REQ-008 The module SHALL have input PCSrcE, 1 bit: a taken branch or jump resolves in E.
REQ-009 The module SHALL have inputs MemReqM and MemReadyM, each 1 bit: a data-memory access is in M, and memory completes it this cycle.
REQ-010 The module SHALL have outputs ForwardAE and ForwardBE, each 2 bits: ALU operand select (00 register file, 01 W result, 10 M ALU result).
REQ-011 The module SHALL have outputs StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, each 1 bit: stage hold and bubble controls.
REQ-012 The module SHALL have output MemErr, 1 bit: sticky memory-timeout fault.
REQ-013 The module SHALL have outputs StallCnt and FlushCnt, each CNT_WIDTH bits: saturating performance counters.

Function
REQ-014 ForwardAE SHALL be combinational: 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E.
REQ-015 lwStall SHALL be defined as ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-016 memBusy SHALL be defined as MemReqM and not MemReadyM.
REQ-017 The FSM SHALL have three states: RUN, MEM_WAIT and FAULT, with a registered 8-bit-minimum wait counter waitCnt.
REQ-018 From RUN, the FSM SHALL go to MEM_WAIT when memBusy, loading waitCnt=1; otherwise it SHALL stay in RUN.
REQ-019 In MEM_WAIT, the FSM SHALL go to RUN when MemReadyM, clearing waitCnt; else it SHALL go to FAULT when waitCnt==WAIT_LIMIT; else waitCnt SHALL increment.
REQ-020 FAULT SHALL be terminal until rst, and MemErr SHALL be 1 exactly when the state is FAULT.
REQ-021 Output priority SHALL be applied per cycle, highest first, as listed in REQ-022 to REQ-026.
REQ-022 In FAULT, StallF, StallD, StallE and StallM SHALL be 1, FlushW SHALL be 1, and all other controls SHALL be 0.
REQ-023 When memBusy (RUN or MEM_WAIT), StallF, StallD, StallE and StallM SHALL be 1 and FlushW SHALL be 1; FlushD and FlushE SHALL be 0, so a pending PCSrcE or lwStall is held rather than acted upon.
REQ-024 Otherwise, when PCSrcE, FlushD and FlushE SHALL be 1 and all stalls SHALL be 0; the branch SHALL win over a simultaneous lwStall.
REQ-025 Otherwise, when lwStall, StallF, StallD and FlushE SHALL be 1.
REQ-026 Otherwise, all stall and flush outputs SHALL be 0.
REQ-027 The MEM_WAIT-to-RUN cycle (MemReadyM=1) SHALL produce no stall from memory, with lower priorities evaluated normally.
REQ-028 StallCnt SHALL increment on each cycle with StallF=1, and FlushCnt SHALL increment on each cycle with FlushE=1.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-030 On rst high, the FSM SHALL enter RUN asynchronously, with waitCnt=0, StallCnt=0, FlushCnt=0 and MemErr=0.
REQ-031 While rst is high, stall and flush outputs SHALL be 0, and forwarding SHALL stay purely combinational.
REQ-032 Asserting rst mid-MEM_WAIT or in FAULT SHALL return the block to RUN.
REQ-033 The first posedge after rst deasserts SHALL evaluate normally.

Verification
REQ-034 Bench case: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with RdM=0 -> ForwardAE=01; with Rs1E=0 and RdW=0 -> 00.
REQ-035 Bench case: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle and StallCnt=1; adding PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-036 Bench case: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=1 and FlushW=1 for 3 cycles, state RUN->MEM_WAIT->RUN, StallCnt=3.
REQ-037 Bench case: PCSrcE=1 during memBusy -> no flush until the release cycle, then FlushD=FlushE=1 and FlushCnt=1.
REQ-038 Bench case: with WAIT_LIMIT=4, MemReadyM held 0 -> FAULT entered after the 4th wait cycle, MemErr=1 sticky, and rst clears it asynchronously.
REQ-039 Bench case: with CNT_WIDTH=4 and 20 load-use stalls -> StallCnt=15, with no wrap.
